// File: rtl/tlb_op_ctrl_if.sv
// Shared types and the bundled port of the TLB instruction controller.
// The master side is the environment: the CSR/exe stage issuing requests,
// the TLB array answering search/read, and the CSR write-back consumer.
// The slave side is tlb_op_ctrl itself.
package tlb_op_ctrl_pkg;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } PhytranItem;

    typedef enum logic [2:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } tlb_op_e;

endpackage

interface tlb_op_ctrl_if #(
    parameter int TLBNUMSIZE = 4
);
    import tlb_op_ctrl_pkg::*;

    // request
    logic                  op_valid;
    logic                  op_ready;
    logic [2:0]            op_type;
    logic [4:0]            op_invop;
    logic [9:0]            op_inv_asid;
    logic [18:0]           op_inv_va;
    // CSR operands
    logic [TLBNUMSIZE-1:0] csr_index;
    logic [5:0]            csr_ps;
    logic                  csr_ne;
    logic [18:0]           csr_vppn;
    logic [9:0]            csr_asid;
    logic                  csr_g;
    PhytranItem            csr_phytran0;
    PhytranItem            csr_phytran1;
    logic                  refill_mode;
    // TLB search port
    logic                  srch_sel;
    logic [18:0]           s1_vppn;
    logic [9:0]            s1_asid;
    logic                  s1_odd;
    logic [TLBNUMSIZE-1:0] s1_index;
    logic                  s1_ne;
    // TLB read port
    logic [TLBNUMSIZE-1:0] r_index;
    logic [5:0]            r_ps;
    logic [9:0]            r_asid;
    logic                  r_ne;
    logic                  r_g;
    logic [18:0]           r_vppn;
    PhytranItem            r_phytran0;
    PhytranItem            r_phytran1;
    // TLB write port
    logic                  we;
    logic [TLBNUMSIZE-1:0] w_index;
    logic [5:0]            w_ps;
    logic                  w_ne;
    logic [9:0]            w_asid;
    logic [18:0]           w_vppn;
    logic                  w_g;
    PhytranItem            w_phytran0;
    PhytranItem            w_phytran1;
    // TLB flush port
    logic                  fe;
    logic [2:0]            f_op;
    logic [9:0]            f_asid;
    logic [18:0]           f_va;
    // result
    logic                  done_valid;
    logic                  done_ready;
    logic [2:0]            res_op;
    logic                  res_err;
    logic [TLBNUMSIZE-1:0] res_index;
    logic                  res_ne;
    logic [5:0]            res_ps;
    logic [9:0]            res_asid;
    logic                  res_g;
    logic [18:0]           res_vppn;
    PhytranItem            res_phytran0;
    PhytranItem            res_phytran1;

    modport master (
        output op_valid, op_type, op_invop, op_inv_asid, op_inv_va,
        output csr_index, csr_ps, csr_ne, csr_vppn, csr_asid, csr_g,
        output csr_phytran0, csr_phytran1, refill_mode,
        output s1_index, s1_ne,
        output r_ps, r_asid, r_ne, r_g, r_vppn, r_phytran0, r_phytran1,
        output done_ready,
        input  op_ready, srch_sel, s1_vppn, s1_asid, s1_odd, r_index,
        input  we, w_index, w_ps, w_ne, w_asid, w_vppn, w_g, w_phytran0, w_phytran1,
        input  fe, f_op, f_asid, f_va,
        input  done_valid, res_op, res_err, res_index, res_ne, res_ps, res_asid,
        input  res_g, res_vppn, res_phytran0, res_phytran1
    );

    modport slave (
        input  op_valid, op_type, op_invop, op_inv_asid, op_inv_va,
        input  csr_index, csr_ps, csr_ne, csr_vppn, csr_asid, csr_g,
        input  csr_phytran0, csr_phytran1, refill_mode,
        input  s1_index, s1_ne,
        input  r_ps, r_asid, r_ne, r_g, r_vppn, r_phytran0, r_phytran1,
        input  done_ready,
        output op_ready, srch_sel, s1_vppn, s1_asid, s1_odd, r_index,
        output we, w_index, w_ps, w_ne, w_asid, w_vppn, w_g, w_phytran0, w_phytran1,
        output fe, f_op, f_asid, f_va,
        output done_valid, res_op, res_err, res_index, res_ne, res_ps, res_asid,
        output res_g, res_vppn, res_phytran0, res_phytran1
    );

endinterface

// File: rtl/tlb_op_ctrl.sv
// TLB instruction controller: runs TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB
// against the TLB array ports and hands the CSR write-back data to the
// consumer over a valid/ready handshake. Owns the TLBFILL round-robin pointer.
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int TLBNUM     = 16,
    parameter int TLBNUMSIZE = 4
) (
    input  logic               clk,
    input  logic               reset,
    tlb_op_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q;
    logic [TLBNUMSIZE-1:0] fill_ptr_q;
    logic [2:0]            op_q;
    logic                  err_q;

    logic                  op_ready_q;
    logic                  srch_sel_q;
    logic [18:0]           s1_vppn_q;
    logic [9:0]            s1_asid_q;
    logic [TLBNUMSIZE-1:0] r_index_q;
    logic                  we_q;
    logic [TLBNUMSIZE-1:0] w_index_q;
    logic [5:0]            w_ps_q;
    logic                  w_ne_q;
    logic [9:0]            w_asid_q;
    logic [18:0]           w_vppn_q;
    logic                  w_g_q;
    PhytranItem            w_phytran0_q;
    PhytranItem            w_phytran1_q;
    logic                  fe_q;
    logic [2:0]            f_op_q;
    logic [9:0]            f_asid_q;
    logic [18:0]           f_va_q;
    logic                  done_valid_q;
    logic [2:0]            res_op_q;
    logic                  res_err_q;
    logic [TLBNUMSIZE-1:0] res_index_q;
    logic                  res_ne_q;
    logic [5:0]            res_ps_q;
    logic [9:0]            res_asid_q;
    logic                  res_g_q;
    logic [18:0]           res_vppn_q;
    PhytranItem            res_phytran0_q;
    PhytranItem            res_phytran1_q;

    logic                  op_illegal;
    logic                  op_is_fill;
    logic                  op_is_wr;
    logic                  op_is_inv;
    logic [TLBNUMSIZE-1:0] fill_ptr_next;

    // Decode the incoming request so its pulses can be registered on accept.
    always_comb begin
        op_is_fill    = (bus.op_type == OP_FILL);
        op_is_wr      = (bus.op_type == OP_WR);
        op_is_inv     = (bus.op_type == OP_INV);
        op_illegal    = (bus.op_type > OP_INV) || (op_is_inv && (bus.op_invop > 5'd6));
        fill_ptr_next = (fill_ptr_q == TLBNUMSIZE'(TLBNUM - 1)) ? '0 : fill_ptr_q + 1'b1;
    end

    // IDLE/EXEC/DONE sequencer; EXEC-cycle port drives are registered at
    // accept so the TLB sees them from flops for exactly the EXEC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            fill_ptr_q     <= '0;
            op_q           <= '0;
            err_q          <= 1'b0;
            op_ready_q     <= 1'b1;
            srch_sel_q     <= 1'b0;
            s1_vppn_q      <= '0;
            s1_asid_q      <= '0;
            r_index_q      <= '0;
            we_q           <= 1'b0;
            w_index_q      <= '0;
            w_ps_q         <= '0;
            w_ne_q         <= 1'b0;
            w_asid_q       <= '0;
            w_vppn_q       <= '0;
            w_g_q          <= 1'b0;
            w_phytran0_q   <= '0;
            w_phytran1_q   <= '0;
            fe_q           <= 1'b0;
            f_op_q         <= '0;
            f_asid_q       <= '0;
            f_va_q         <= '0;
            done_valid_q   <= 1'b0;
            res_op_q       <= '0;
            res_err_q      <= 1'b0;
            res_index_q    <= '0;
            res_ne_q       <= 1'b0;
            res_ps_q       <= '0;
            res_asid_q     <= '0;
            res_g_q        <= 1'b0;
            res_vppn_q     <= '0;
            res_phytran0_q <= '0;
            res_phytran1_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.op_valid) begin
                        state_q      <= EXEC;
                        op_ready_q   <= 1'b0;
                        op_q         <= bus.op_type;
                        err_q        <= op_illegal;
                        srch_sel_q   <= (bus.op_type == OP_SRCH);
                        we_q         <= op_is_wr || op_is_fill;
                        fe_q         <= op_is_inv && !op_illegal;
                        s1_vppn_q    <= bus.csr_vppn;
                        s1_asid_q    <= bus.csr_asid;
                        r_index_q    <= bus.csr_index;
                        w_index_q    <= op_is_fill ? fill_ptr_q : bus.csr_index;
                        w_ps_q       <= bus.csr_ps;
                        w_ne_q       <= bus.refill_mode ? 1'b0 : bus.csr_ne;
                        w_asid_q     <= bus.csr_asid;
                        w_vppn_q     <= bus.csr_vppn;
                        w_g_q        <= bus.csr_g;
                        w_phytran0_q <= bus.csr_phytran0;
                        w_phytran1_q <= bus.csr_phytran1;
                        f_op_q       <= bus.op_invop[2:0];
                        f_asid_q     <= bus.op_inv_asid;
                        f_va_q       <= bus.op_inv_va;
                    end
                end
                EXEC: begin
                    state_q        <= DONE;
                    srch_sel_q     <= 1'b0;
                    we_q           <= 1'b0;
                    fe_q           <= 1'b0;
                    done_valid_q   <= 1'b1;
                    res_op_q       <= op_q;
                    res_err_q      <= err_q;
                    res_index_q    <= '0;
                    res_ne_q       <= 1'b0;
                    res_ps_q       <= '0;
                    res_asid_q     <= '0;
                    res_g_q        <= 1'b0;
                    res_vppn_q     <= '0;
                    res_phytran0_q <= '0;
                    res_phytran1_q <= '0;
                    case (op_q)
                        OP_SRCH: begin
                            res_ne_q    <= bus.s1_ne;
                            res_index_q <= bus.s1_ne ? '0 : bus.s1_index;
                        end
                        OP_RD: begin
                            res_index_q    <= r_index_q;
                            res_ne_q       <= bus.r_ne;
                            res_ps_q       <= bus.r_ps;
                            res_asid_q     <= bus.r_asid;
                            res_g_q        <= bus.r_g;
                            res_vppn_q     <= bus.r_vppn;
                            res_phytran0_q <= bus.r_phytran0;
                            res_phytran1_q <= bus.r_phytran1;
                        end
                        OP_FILL: begin
                            res_index_q <= fill_ptr_q;
                            fill_ptr_q  <= fill_ptr_next;
                        end
                        default: ;
                    endcase
                end
                DONE: begin
                    if (bus.done_ready) begin
                        state_q      <= IDLE;
                        done_valid_q <= 1'b0;
                        op_ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    op_ready_q   <= 1'b1;
                    done_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.op_ready     = op_ready_q;
    assign bus.srch_sel     = srch_sel_q;
    assign bus.s1_vppn      = s1_vppn_q;
    assign bus.s1_asid      = s1_asid_q;
    assign bus.s1_odd       = 1'b0;
    assign bus.r_index      = r_index_q;
    assign bus.we           = we_q;
    assign bus.w_index      = w_index_q;
    assign bus.w_ps         = w_ps_q;
    assign bus.w_ne         = w_ne_q;
    assign bus.w_asid       = w_asid_q;
    assign bus.w_vppn       = w_vppn_q;
    assign bus.w_g          = w_g_q;
    assign bus.w_phytran0   = w_phytran0_q;
    assign bus.w_phytran1   = w_phytran1_q;
    assign bus.fe           = fe_q;
    assign bus.f_op         = f_op_q;
    assign bus.f_asid       = f_asid_q;
    assign bus.f_va         = f_va_q;
    assign bus.done_valid   = done_valid_q;
    assign bus.res_op       = res_op_q;
    assign bus.res_err      = res_err_q;
    assign bus.res_index    = res_index_q;
    assign bus.res_ne       = res_ne_q;
    assign bus.res_ps       = res_ps_q;
    assign bus.res_asid     = res_asid_q;
    assign bus.res_g        = res_g_q;
    assign bus.res_vppn     = res_vppn_q;
    assign bus.res_phytran0 = res_phytran0_q;
    assign bus.res_phytran1 = res_phytran1_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a small behavioural TLB array
// answering the search and read ports and absorbing writes.
module tb_tlb_op_ctrl;
    import tlb_op_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    tlb_op_ctrl_if #(.TLBNUMSIZE(4)) bus ();

    tlb_op_ctrl #(.TLBNUM(16), .TLBNUMSIZE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // behavioural TLB array
    logic [18:0] m_vppn [16];
    logic [9:0]  m_asid [16];
    logic [5:0]  m_ps   [16];
    logic        m_g    [16];
    logic        m_ne   [16] = '{default: 1'b1};
    PhytranItem  m_p0   [16];
    PhytranItem  m_p1   [16];

    always @(posedge clk) begin
        if (bus.we) begin
            m_vppn[bus.w_index] <= bus.w_vppn;
            m_asid[bus.w_index] <= bus.w_asid;
            m_ps[bus.w_index]   <= bus.w_ps;
            m_g[bus.w_index]    <= bus.w_g;
            m_ne[bus.w_index]   <= bus.w_ne;
            m_p0[bus.w_index]   <= bus.w_phytran0;
            m_p1[bus.w_index]   <= bus.w_phytran1;
        end
    end

    // search returns a junk index on miss so the controller must zero it
    always_comb begin
        bus.s1_index = 4'hF;
        bus.s1_ne    = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            if (!m_ne[i] && m_vppn[i] == bus.s1_vppn && (m_g[i] || m_asid[i] == bus.s1_asid)) begin
                bus.s1_index = 4'(i);
                bus.s1_ne    = 1'b0;
            end
        end
        bus.r_ps       = m_ps[bus.r_index];
        bus.r_asid     = m_asid[bus.r_index];
        bus.r_ne       = m_ne[bus.r_index];
        bus.r_g        = m_g[bus.r_index];
        bus.r_vppn     = m_vppn[bus.r_index];
        bus.r_phytran0 = m_p0[bus.r_index];
        bus.r_phytran1 = m_p1[bus.r_index];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise op_valid, wait for op_ready, return #1 after the accept edge (EXEC).
    task automatic start_op(input logic [2:0] t);
        int unsigned n;
        n = 0;
        bus.op_type  = t;
        bus.op_valid = 1'b1;
        while (!bus.op_ready && n < 20) begin
            step();
            n++;
        end
        if (!bus.op_ready) check("ready_timeout", 32'd0, 32'd1);
        step();
        bus.op_valid = 1'b0;
    endtask

    PhytranItem p0, p1;

    initial begin
        bus.op_valid     = 1'b0;
        bus.op_type      = '0;
        bus.op_invop     = '0;
        bus.op_inv_asid  = '0;
        bus.op_inv_va    = '0;
        bus.csr_index    = '0;
        bus.csr_ps       = '0;
        bus.csr_ne       = 1'b0;
        bus.csr_vppn     = '0;
        bus.csr_asid     = '0;
        bus.csr_g        = 1'b0;
        bus.csr_phytran0 = '0;
        bus.csr_phytran1 = '0;
        bus.refill_mode  = 1'b0;
        bus.done_ready   = 1'b1;

        step(); step(); step();
        check("rst_ready", bus.op_ready, 1);
        check("rst_we", bus.we, 0);
        check("rst_fe", bus.fe, 0);
        check("rst_srch", bus.srch_sel, 0);
        check("rst_done", bus.done_valid, 0);
        check("rst_residx", bus.res_index, 0);
        check("rst_resvppn", bus.res_vppn, 0);
        reset = 1'b0;

        // FILL x17: round-robin pointer wraps back to 0
        for (int i = 0; i < 17; i++) begin
            bus.csr_vppn = 19'h100 + 19'(i);
            bus.csr_asid = 10'h3;
            bus.csr_ps   = 6'd12;
            bus.csr_g    = 1'b0;
            bus.csr_ne   = 1'b0;
            start_op(OP_FILL);
            check("fill_we", bus.we, 1);
            check("fill_fe", bus.fe, 0);
            check("fill_widx", bus.w_index, 32'(i % 16));
            check("fill_wvppn", bus.w_vppn, 32'h100 + 32'(i));
            step();
            check("fill_we_pulse", bus.we, 0);
            check("fill_done", bus.done_valid, 1);
            check("fill_resop", bus.res_op, 3);
            check("fill_residx", bus.res_index, 32'(i % 16));
            step();
            check("fill_idle", bus.op_ready, 1);
        end

        // WR in refill mode forces w_ne=0
        p0 = '{ppn: 20'hABCDE, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1};
        p1 = '{ppn: 20'h12345, plv: 2'd0, mat: 2'd2, d: 1'b0, v: 1'b1};
        bus.csr_index    = 4'd5;
        bus.csr_ne       = 1'b1;
        bus.refill_mode  = 1'b1;
        bus.csr_vppn     = 19'h5A5A5;
        bus.csr_asid     = 10'h2C1;
        bus.csr_ps       = 6'd21;
        bus.csr_g        = 1'b1;
        bus.csr_phytran0 = p0;
        bus.csr_phytran1 = p1;
        start_op(OP_WR);
        check("wr_we", bus.we, 1);
        check("wr_widx", bus.w_index, 5);
        check("wr_wne", bus.w_ne, 0);
        check("wr_wps", bus.w_ps, 21);
        check("wr_wp0", bus.w_phytran0, 32'(p0));
        step();
        check("wr_we_pulse", bus.we, 0);
        check("wr_resop", bus.res_op, 2);
        check("wr_reserr", bus.res_err, 0);
        step();

        // RD of entry 5; scramble CSR operands so data must come from r_*
        bus.refill_mode  = 1'b0;
        bus.csr_ne       = 1'b0;
        bus.csr_vppn     = '0;
        bus.csr_asid     = '0;
        bus.csr_ps       = '0;
        bus.csr_g        = 1'b0;
        bus.csr_phytran0 = '0;
        bus.csr_phytran1 = '0;
        start_op(OP_RD);
        check("rd_ridx", bus.r_index, 5);
        check("rd_we", bus.we, 0);
        step();
        check("rd_done", bus.done_valid, 1);
        check("rd_resne", bus.res_ne, 0);
        check("rd_resvppn", bus.res_vppn, 32'h5A5A5);
        check("rd_resasid", bus.res_asid, 32'h2C1);
        check("rd_resps", bus.res_ps, 21);
        check("rd_resg", bus.res_g, 1);
        check("rd_resp0", bus.res_phytran0, 32'(p0));
        check("rd_resp1", bus.res_phytran1, 32'(p1));
        step();

        // SRCH hit on entry 9 (filled with vppn 0x109, asid 3)
        bus.csr_vppn = 19'h109;
        bus.csr_asid = 10'h3;
        start_op(OP_SRCH);
        check("srch_sel", bus.srch_sel, 1);
        check("srch_vppn", bus.s1_vppn, 32'h109);
        check("srch_odd", bus.s1_odd, 0);
        step();
        check("srch_sel_pulse", bus.srch_sel, 0);
        check("srch_hit_idx", bus.res_index, 9);
        check("srch_hit_ne", bus.res_ne, 0);
        step();

        // SRCH miss
        bus.csr_vppn = 19'h7FFFF;
        start_op(OP_SRCH);
        step();
        check("srch_miss_ne", bus.res_ne, 1);
        check("srch_miss_idx", bus.res_index, 0);
        step();

        // INVTLB op 5
        bus.op_invop    = 5'd5;
        bus.op_inv_asid = 10'h3;
        bus.op_inv_va   = 19'h1234;
        start_op(OP_INV);
        check("inv_fe", bus.fe, 1);
        check("inv_we", bus.we, 0);
        check("inv_fop", bus.f_op, 5);
        check("inv_fasid", bus.f_asid, 32'h3);
        check("inv_fva", bus.f_va, 32'h1234);
        step();
        check("inv_fe_pulse", bus.fe, 0);
        check("inv_reserr", bus.res_err, 0);
        step();

        // INVTLB op 9 is illegal
        bus.op_invop = 5'd9;
        start_op(OP_INV);
        check("inv9_fe", bus.fe, 0);
        check("inv9_we", bus.we, 0);
        step();
        check("inv9_reserr", bus.res_err, 1);
        check("inv9_resop", bus.res_op, 4);
        step();

        // op_type 6 is illegal
        start_op(3'd6);
        check("op6_we", bus.we, 0);
        check("op6_fe", bus.fe, 0);
        step();
        check("op6_reserr", bus.res_err, 1);
        check("op6_resop", bus.res_op, 6);
        step();

        // backpressure: hold result 4 cycles, a new request is ignored
        bus.done_ready = 1'b0;
        bus.csr_index  = 4'd5;
        start_op(OP_RD);
        step();
        bus.op_type  = OP_FILL;
        bus.op_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_done", bus.done_valid, 1);
            check("bp_ready", bus.op_ready, 0);
            check("bp_vppn", bus.res_vppn, 32'h5A5A5);
            check("bp_resop", bus.res_op, 1);
            check("bp_we", bus.we, 0);
            step();
        end
        bus.op_valid   = 1'b0;
        bus.done_ready = 1'b1;
        step();
        check("bp_rel_ready", bus.op_ready, 1);
        check("bp_rel_done", bus.done_valid, 0);

        // reset during FILL EXEC; pointer is at 1 after 17 fills
        start_op(OP_FILL);
        check("rstx_widx", bus.w_index, 1);
        reset = 1'b1;
        step();
        check("rstx_we", bus.we, 0);
        check("rstx_done", bus.done_valid, 0);
        check("rstx_ready", bus.op_ready, 1);
        reset = 1'b0;
        start_op(OP_FILL);
        check("rstx_ptr0", bus.w_index, 0);
        step();
        check("rstx_residx", bus.res_index, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
